// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer and its companion 1-bit ALU:
// ALU opcodes, shift-type codes and sequencer state encodings.
package shift_sequencer_pkg;

   // ALU opcodes; shift/rotate opcodes are {1'b1, shift_type}
   localparam logic [3:0] OP_PASS = 4'b0000;
   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_ASR  = 4'b1000;
   localparam logic [3:0] OP_LSL  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
   localparam logic [3:0] OP_ROL  = 4'b1100;
   localparam logic [3:0] OP_ROR  = 4'b1101;

   localparam logic [2:0] SH_ASR = 3'b000;
   localparam logic [2:0] SH_LSL = 3'b001;
   localparam logic [2:0] SH_LSR = 3'b010;
   localparam logic [2:0] SH_ROL = 3'b100;
   localparam logic [2:0] SH_ROR = 3'b101;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_RUN  = 2'b01;
   localparam state_t ST_DONE = 2'b10;

   function automatic logic sh_type_valid(input logic [2:0] t);
      logic v;
      case (t)
         SH_ASR, SH_LSL, SH_LSR, SH_ROL, SH_ROR: v = 1'b1;
         default:                                v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/shift_sequencer_alu.sv
// Single-operand ALU used beside the shift sequencer: pass, invert and
// 1-bit shift/rotate, purely combinational.
module shift_sequencer_alu
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_out,
   output logic             o_zero
);

   logic [WIDTH-1:0] w_res;

   always_comb begin
      w_res = i_a;
      case (i_op)
         OP_PASS: w_res = i_a;
         OP_NOT:  w_res = ~i_a;
         OP_ASR:  w_res = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
         OP_LSL:  w_res = {i_a[WIDTH-2:0], 1'b0};
         OP_LSR:  w_res = {1'b0, i_a[WIDTH-1:1]};
         OP_ROL:  w_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
         OP_ROR:  w_res = {i_a[0], i_a[WIDTH-1:1]};
         default: w_res = i_a;
      endcase
   end

   assign o_out  = w_res;
   assign o_zero = (w_res == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: drives a 1-bit-shift ALU once per
// clock from its accumulator and reports Result/Zero/Err with a Done pulse.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [4:0]       ShAmt,
   input  logic [2:0]       ShType,
   input  logic [WIDTH-1:0] AluOut,
   input  logic             AluZero,
   output logic [WIDTH-1:0] AluA,
   output logic [3:0]       AluOp,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Done,
   output logic             Busy,
   output logic             Err
);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [4:0]       r_count;
   logic [2:0]       r_type;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_err;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_count  <= '0;
         r_type   <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  if (!sh_type_valid(ShType)) begin
                     r_err   <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (ShAmt == 5'd0) begin
                     r_result <= A;
                     r_zero   <= (A == '0);
                     r_err    <= 1'b0;
                     r_state  <= ST_DONE;
                  end else begin
                     r_acc   <= A;
                     r_count <= ShAmt;
                     r_type  <= ShType;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_acc   <= AluOut;
               r_count <= r_count - 5'd1;
               // Last step: capture the ALU output directly, not the accumulator
               if (r_count == 5'd1) begin
                  r_result <= AluOut;
                  r_zero   <= AluZero;
                  r_err    <= 1'b0;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign AluA   = r_acc;
   assign AluOp  = (r_state == ST_RUN) ? {1'b1, r_type} : OP_PASS;
   assign Result = r_result;
   assign Zero   = r_zero;
   assign Err    = r_err;
   assign Done   = (r_state == ST_DONE);
   assign Busy   = (r_state != ST_IDLE);

endmodule
